// File: rtl/chk_pkg.sv
// Shared types and helpers for the counter-pattern stream checker.
package chk_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } chk_st_t;

  localparam int CHK_CW = 32;

  function automatic int chk_nwords(input int dw, input int sw);
    return dw / sw;
  endfunction

endpackage

// File: rtl/chk_lat_stats.sv
// Latency min/max tracker for timestamped beats; active only when CHK_LATENCY_EN is defined,
// otherwise the outputs hold their reset values.
module chk_lat_stats #(
  parameter int TSW     = 32,
  parameter int LAT_CAP = 50
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr,
  input  logic           sample,
  input  logic [TSW-1:0] lat,
  output logic [TSW-1:0] lat_min,
  output logic [TSW-1:0] lat_max,
  output logic           lat_vld
);

`ifdef CHK_LATENCY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_min <= '1;
      lat_max <= '0;
      lat_vld <= 1'b0;
    end else begin
      lat_vld <= sample;
      // a clear in the same cycle as a sample discards that sample
      if (clr) begin
        lat_min <= '1;
        lat_max <= '0;
      end else if (sample) begin
        if ((lat != '0) && (lat < lat_min))
          lat_min <= lat;
        if ((lat > lat_max) && (lat < TSW'(LAT_CAP)))
          lat_max <= lat;
      end
    end
  end
`else
  logic unused_lat;
  assign unused_lat = ^{clk, reset_n, clr, sample, lat};
  assign lat_min    = '1;
  assign lat_max    = '0;
  assign lat_vld    = 1'b0;
`endif

endmodule

// File: rtl/chk_seq_stream.sv
// Receive-side checker for counter-pattern traffic: lock FSM, error/beat counters, bandwidth
// window and (with CHK_LATENCY_EN defined) timestamp latency statistics.
//
//  state  | meaning
//  HUNT   | next beat only seeds the reference word
//  CHECK  | counting consecutive matching beats towards lock
//  LOCKED | locked; mismatches are errors, MISS_MAX in a row drop lock
module chk_seq_stream
  import chk_pkg::*;
#(
  parameter int DW       = 192,
  parameter int SW       = 12,
  parameter int TSW      = 32,
  parameter int LOCK_CNT = 2,
  parameter int MISS_MAX = 4,
  parameter int LAT_CAP  = 50,
  parameter int BW_WIN   = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vld,
  input  logic [DW-1:0]     data,
  input  logic              ts_vld,
  input  logic [TSW-1:0]    now,
  input  logic              clr_stats,
  output logic              good,
  output logic              err,
  output logic              locked,
  output logic [CHK_CW-1:0] err_cnt,
  output logic [CHK_CW-1:0] beat_cnt,
  output logic [TSW-1:0]    lat_min,
  output logic [TSW-1:0]    lat_max,
  output logic              lat_vld,
  output logic [CHK_CW-1:0] bw_beats,
  output logic              bw_vld
);

  localparam int NW = chk_nwords(DW, SW);
  localparam logic [SW-1:0] NW_MASK = SW'(NW - 1);
  localparam int OKW = $clog2(LOCK_CNT + 1);
  localparam int MSW = $clog2(MISS_MAX + 1);
  localparam int BCW = (BW_WIN > 1) ? $clog2(BW_WIN) : 1;
`ifdef CHK_LATENCY_EN
  localparam int TS_WORDS = (TSW + SW - 1) / SW;
`endif

  chk_st_t           st;
  logic [SW-1:0]     ref_w;
  logic [SW-1:0]     ref_p1;
  logic [NW-1:0]     word_ok;
  logic              aligned;
  logic              match;
  logic              good_now;
  logic              err_now;
  logic              lat_sample;
  logic [OKW-1:0]    ok_cnt;
  logic [MSW-1:0]    miss_cnt;
  logic [BCW-1:0]    bw_cyc;
  logic [CHK_CW-1:0] bw_acc;
  logic [TSW-1:0]    lat;

  assign ref_p1  = ref_w + 1'b1;
  assign aligned = (ref_p1 & NW_MASK) == '0;

  for (genvar k = 0; k < NW; k++) begin : g_word
    logic [SW-1:0] exp_w;
    assign exp_w = ref_w + SW'(k + 1);
`ifdef CHK_LATENCY_EN
    localparam bit TS_EXCL = (k < TS_WORDS);
    assign word_ok[k] = (data[SW*k +: SW] == exp_w) || (ts_vld && TS_EXCL);
`else
    assign word_ok[k] = (data[SW*k +: SW] == exp_w);
`endif
  end

  assign match      = aligned && (&word_ok);
  assign good_now   = vld && match && (st != HUNT);
  assign err_now    = vld && !match && (st == LOCKED);
  assign lat_sample = vld && ts_vld && match && (st == LOCKED);
  assign lat        = now - data[TSW-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st       <= HUNT;
      ref_w    <= '0;
      ok_cnt   <= '0;
      miss_cnt <= '0;
      good     <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
    end else begin
      good <= good_now;
      err  <= err_now;
      if (vld) begin
        // reference always follows the stream so a slipped pattern resyncs by itself
        ref_w <= data[DW-1 -: SW];
        case (st)
          HUNT: begin
            ok_cnt <= '0;
            st     <= CHECK;
          end
          CHECK: begin
            if (match) begin
              ok_cnt <= ok_cnt + 1'b1;
              if (ok_cnt == OKW'(LOCK_CNT - 1)) begin
                st       <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              ok_cnt <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
              if (miss_cnt == MSW'(MISS_MAX - 1)) begin
                st     <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            st     <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr_stats) begin
      err_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (err_now && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
      if (good_now && (beat_cnt != '1))
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bw_cyc   <= '0;
      bw_acc   <= '0;
      bw_beats <= '0;
      bw_vld   <= 1'b0;
    end else if (bw_cyc == BCW'(BW_WIN - 1)) begin
      bw_cyc   <= '0;
      bw_acc   <= '0;
      bw_beats <= bw_acc + CHK_CW'(good_now);
      bw_vld   <= 1'b1;
    end else begin
      bw_cyc <= bw_cyc + 1'b1;
      bw_acc <= bw_acc + CHK_CW'(good_now);
      bw_vld <= 1'b0;
    end
  end

  chk_lat_stats #(
    .TSW     (TSW),
    .LAT_CAP (LAT_CAP)
  ) u_lat_stats (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_stats),
    .sample  (lat_sample),
    .lat     (lat),
    .lat_min (lat_min),
    .lat_max (lat_max),
    .lat_vld (lat_vld)
  );

endmodule

// File: tb/tb_chk_seq_stream.sv
// Bench for chk_seq_stream: reference model driven from the pattern rules, directed and
// random beats; latency scenario depends on CHK_LATENCY_EN.
module tb_chk_seq_stream;

  localparam int DW       = 192;
  localparam int SW       = 12;
  localparam int TSW      = 32;
  localparam int LOCK_CNT = 2;
  localparam int MISS_MAX = 4;
  localparam int LAT_CAP  = 50;
  localparam int BW_WIN   = 1000;
  localparam int NW       = DW / SW;
  localparam int TS_WORDS = (TSW + SW - 1) / SW;
  localparam int VW       = 3 + 32 + 32 + 2 * TSW + 1 + 32 + 1;
`ifdef CHK_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n, vld, ts_vld, clr_stats;
  logic [DW-1:0]  data;
  logic [TSW-1:0] now;
  logic           good, err, locked, lat_vld, bw_vld;
  logic [31:0]    err_cnt, beat_cnt, bw_beats;
  logic [TSW-1:0] lat_min, lat_max;

  chk_seq_stream #(
    .DW(DW), .SW(SW), .TSW(TSW), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX),
    .LAT_CAP(LAT_CAP), .BW_WIN(BW_WIN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vld(vld), .data(data), .ts_vld(ts_vld), .now(now),
    .clr_stats(clr_stats), .good(good), .err(err), .locked(locked), .err_cnt(err_cnt),
    .beat_cnt(beat_cnt), .lat_min(lat_min), .lat_max(lat_max), .lat_vld(lat_vld),
    .bw_beats(bw_beats), .bw_vld(bw_vld)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] dut_vec = {good, err, locked, err_cnt, beat_cnt, lat_min, lat_max, lat_vld,
                           bw_beats, bw_vld};
  logic [VW-1:0] exp_vec;

  // reference model state
  int             m_ref, m_run, m_miss, m_cyc, m_acc;
  bit             m_hunt, m_lock;
  bit             e_good, e_err, e_locked, e_lat_vld, e_bw_vld;
  logic [31:0]    e_err_cnt, e_beat_cnt, e_bw_beats;
  logic [TSW-1:0] e_lat_min, e_lat_max;

  logic [SW-1:0]  last_top;
  logic [TSW-1:0] tnow;
  int             nb;
  int             n_vec, n_bad;

  function automatic logic [DW-1:0] mk_beat(input int base);
    logic [DW-1:0] d;
    for (int k = 0; k < NW; k++) d[SW*k +: SW] = SW'(base + k);
    return d;
  endfunction

  function automatic int next_aligned();
    return ((int'(last_top) + NW) / NW) * NW;
  endfunction

  function automatic bit model_match(input logic [DW-1:0] d, input bit tsv);
    logic [SW-1:0] w;
    if (((m_ref + 1) % NW) != 0) return 1'b0;
    for (int k = 0; k < NW; k++) begin
      w = d[SW*k +: SW];
      if (LAT_EN && tsv && (k < TS_WORDS)) continue;
      if (int'(w) != ((m_ref + k + 1) % (1 << SW))) return 1'b0;
    end
    return 1'b1;
  endfunction

  // one clock: drive inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input bit rn, input bit v, input logic [DW-1:0] d, input bit tsv,
                      input bit clr);
    bit mt;
    logic [TSW-1:0] lat;
    reset_n = rn; vld = v; data = d; ts_vld = tsv; clr_stats = clr; now = tnow;
    mt  = model_match(d, tsv);
    lat = tnow - d[TSW-1:0];
    if (!rn) begin
      m_ref = 0; m_run = 0; m_miss = 0; m_cyc = 0; m_acc = 0;
      m_hunt = 1; m_lock = 0;
      e_good = 0; e_err = 0; e_locked = 0; e_lat_vld = 0; e_bw_vld = 0;
      e_err_cnt = 0; e_beat_cnt = 0; e_bw_beats = 0;
      e_lat_min = '1; e_lat_max = '0;
    end else begin
      e_good    = v && !m_hunt && mt;
      e_err     = v && m_lock && !mt;
      e_lat_vld = LAT_EN && v && tsv && m_lock && mt;
      if (e_lat_vld) begin
        if (lat != 0 && lat < e_lat_min) e_lat_min = lat;
        if (lat > e_lat_max && lat < LAT_CAP) e_lat_max = lat;
      end
      if (e_good && e_beat_cnt != 32'hFFFF_FFFF) e_beat_cnt = e_beat_cnt + 1;
      if (e_err && e_err_cnt != 32'hFFFF_FFFF) e_err_cnt = e_err_cnt + 1;
      if (clr) begin
        e_beat_cnt = 0; e_err_cnt = 0; e_lat_min = '1; e_lat_max = '0;
      end
      if (m_cyc == BW_WIN - 1) begin
        e_bw_beats = m_acc + int'(e_good); e_bw_vld = 1; m_acc = 0; m_cyc = 0;
      end else begin
        e_bw_vld = 0; m_acc += int'(e_good); m_cyc++;
      end
      if (v) begin
        if (m_hunt) begin
          m_hunt = 0; m_run = 0;
        end else if (!m_lock) begin
          if (mt) begin
            m_run++;
            if (m_run >= LOCK_CNT) begin m_lock = 1; m_miss = 0; end
          end else m_run = 0;
        end else begin
          if (mt) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss >= MISS_MAX) begin m_lock = 0; m_hunt = 1; end
          end
        end
        m_ref    = int'(d[DW-1 -: SW]);
        last_top = d[DW-1 -: SW];
      end
      e_locked = m_lock;
    end
    exp_vec = {e_good, e_err, e_locked, e_err_cnt, e_beat_cnt, e_lat_min, e_lat_max,
               e_lat_vld, e_bw_beats, e_bw_vld};
    @(posedge clk);
    #1;
    tnow = tnow + 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], mk_beat(i * 7), 1'b0, 1'b0);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL reset%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (good !== 0 || err !== 0 || locked !== 0 || err_cnt !== 0 || beat_cnt !== 0 ||
        lat_min !== {TSW{1'b1}} || lat_max !== 0 || lat_vld !== 0 || bw_beats !== 0 ||
        bw_vld !== 0) begin
      n_bad++; $display("FAIL reset_values dut=%h", dut_vec);
    end
  endtask

  task automatic test_lock();
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, mk_beat(nb), 0, 0);
      nb += NW;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL lock beat%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
      if (i == 1) begin
        n_vec++;
        if (locked !== 1'b0 || good !== 1'b1) begin
          n_bad++; $display("FAIL lock_beat2 locked=%b good=%b exp 0 1", locked, good);
        end
      end
    end
    n_vec++;
    if (locked !== 1'b1 || err_cnt !== 0 || beat_cnt !== 2) begin
      n_bad++;
      $display("FAIL lock_beat3 locked=%b err_cnt=%0d beat_cnt=%0d exp 1 0 2",
               locked, err_cnt, beat_cnt);
    end
  endtask

  task automatic test_single_error();
    logic [DW-1:0] d;
    d = mk_beat(nb);
    d[SW*5 +: SW] = ~d[SW*5 +: SW];
    step(1, 1, d, 0, 0);
    nb += NW;
    n_vec++;
    if (dut_vec !== exp_vec) begin
      n_bad++; $display("FAIL single_err dut=%h exp=%h", dut_vec, exp_vec);
    end
    n_vec++;
    if (err !== 1'b1 || good !== 1'b0 || err_cnt !== 1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_err_flags err=%b good=%b err_cnt=%0d locked=%b exp 1 0 1 1",
               err, good, err_cnt, locked);
    end
    step(1, 1, mk_beat(nb), 0, 0);
    nb += NW;
    n_vec++;
    if (good !== 1'b1 || err !== 1'b0 || locked !== 1'b1 || dut_vec !== exp_vec) begin
      n_bad++; $display("FAIL single_err_next dut=%h exp=%h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_lose_lock();
    step(1, 0, '0, 0, 1);
    n_vec++;
    if (dut_vec !== exp_vec) begin
      n_bad++; $display("FAIL lose_clr dut=%h exp=%h", dut_vec, exp_vec);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, mk_beat(nb + 8 + NW * i), 0, 0);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL lose beat%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
      if (i == 2) begin
        n_vec++;
        if (locked !== 1'b1 || err !== 1'b1) begin
          n_bad++; $display("FAIL lose_beat3 locked=%b err=%b exp 1 1", locked, err);
        end
      end
    end
    n_vec++;
    if (err_cnt !== 4 || locked !== 1'b0) begin
      n_bad++; $display("FAIL lose_beat4 err_cnt=%0d locked=%b exp 4 0", err_cnt, locked);
    end
    nb += 128;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, mk_beat(nb), 0, 0);
      nb += NW;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL relock beat%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (locked !== 1'b1 || err_cnt !== 4) begin
      n_bad++; $display("FAIL relock locked=%b err_cnt=%0d exp 1 4", locked, err_cnt);
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] d;
    bit tsv;
`ifdef CHK_LATENCY_EN
    step(1, 0, '0, 0, 1);
    d = mk_beat(nb);
    d[TSW-1:0] = tnow - 30;
    step(1, 1, d, 1, 0);
    nb += NW;
    n_vec++;
    if (lat_vld !== 1'b1 || lat_min !== 30 || lat_max !== 30 || good !== 1'b1 ||
        dut_vec !== exp_vec) begin
      n_bad++; $display("FAIL lat30 dut=%h exp=%h", dut_vec, exp_vec);
    end
    d = mk_beat(nb);
    d[TSW-1:0] = tnow - 60;
    step(1, 1, d, 1, 0);
    nb += NW;
    n_vec++;
    if (lat_vld !== 1'b1 || lat_min !== 30 || lat_max !== 30 || dut_vec !== exp_vec) begin
      n_bad++; $display("FAIL lat60 min=%0d max=%0d exp 30 30", lat_min, lat_max);
    end
    step(1, 0, '0, 0, 0);
    n_vec++;
    if (lat_vld !== 1'b0) begin
      n_bad++; $display("FAIL lat_pulse lat_vld=%b exp 0", lat_vld);
    end
`else
    step(1, 1, mk_beat(nb), 1, 0);
    nb += NW;
    n_vec++;
    if (good !== 1'b1 || lat_vld !== 1'b0 || lat_min !== {TSW{1'b1}} || lat_max !== 0) begin
      n_bad++; $display("FAIL lat_off dut=%h", dut_vec);
    end
`endif
    for (int i = 0; i < 40; i++) begin
      d   = mk_beat(nb);
      tsv = ($urandom_range(0, 1) == 1);
      if (LAT_EN && tsv) d[TSW-1:0] = tnow - TSW'($urandom_range(0, 70));
      step(1, 1, d, tsv, 0);
      nb += NW;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL lat_rand%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_bandwidth();
    nb = next_aligned();
    for (int i = 0; i < 2100; i++) begin
      step(1, 1, mk_beat(nb), 0, 0);
      nb += NW;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL bw_full%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (bw_beats !== 1000) begin
      n_bad++; $display("FAIL bw_full bw_beats=%0d exp 1000", bw_beats);
    end
    for (int i = 0; i < 2100; i++) begin
      if (i % 2 == 0) begin
        step(1, 1, mk_beat(nb), 0, 0);
        nb += NW;
      end else begin
        step(1, 0, mk_beat(nb + 3), 0, 0);
      end
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL bw_half%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (bw_beats !== 500) begin
      n_bad++; $display("FAIL bw_half bw_beats=%0d exp 500", bw_beats);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      bit v, tsv, clr;
      int r, k, base;
      v    = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      tsv  = 1'b0;
      r    = $urandom_range(0, 99);
      base = int'(last_top) + 1;
      if (r < 78) d = mk_beat(base);
      else if (r < 86) begin
        d = mk_beat(base);
        k = $urandom_range(0, NW - 1);
        d[SW*k +: SW] = d[SW*k +: SW] ^ SW'($urandom_range(1, (1 << SW) - 1));
      end else if (r < 91) d = mk_beat(base + $urandom_range(1, NW - 1));
      else if (r < 95) begin
        for (int j = 0; j < DW / 32; j++) d[32*j +: 32] = $urandom();
      end else d = mk_beat(NW * $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        tsv = 1'b1;
        d[TSW-1:0] = tnow - TSW'($urandom_range(0, 80));
      end
      step(1, v, d, tsv, clr);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL rand%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    nb = next_aligned();
    for (int i = 0; i < 49; i++) begin
      step(1, 1, mk_beat(nb), 0, 0);
      nb += NW;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL pre_rst%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL pre_rst_lock locked=%b exp 1", locked);
    end
    step(0, 1, mk_beat(nb), 0, 0);
    n_vec++;
    if (locked !== 1'b0 || err_cnt !== 0 || beat_cnt !== 0 || lat_min !== {TSW{1'b1}} ||
        bw_beats !== 0 || dut_vec !== exp_vec) begin
      n_bad++; $display("FAIL mid_reset dut=%h exp=%h", dut_vec, exp_vec);
    end
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, mk_beat(nb), 0, 0);
      nb += NW;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++; $display("FAIL post_rst%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (locked !== 1'b1 || beat_cnt !== 2 || err_cnt !== 0) begin
      n_bad++;
      $display("FAIL post_rst_lock locked=%b beat_cnt=%0d err_cnt=%0d exp 1 2 0",
               locked, beat_cnt, err_cnt);
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; tnow = 1000; last_top = '0; nb = 0;
    reset_n = 1'b0; vld = 1'b0; ts_vld = 1'b0; clr_stats = 1'b0; data = '0; now = '0;
    test_reset();
    test_lock();
    test_single_error();
    test_lose_lock();
    test_latency();
    test_bandwidth();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
